// File: rtl/exe_unit_mc.sv
// Multi-cycle execute stage: forwarding operand muxes, single-cycle ALU with registered
// result, and iterative unsigned MUL/DIVU/REMU behind valid/ready handshakes.
module exe_unit_mc #(
   parameter int WIDTH  = 32,
   parameter int SH_LSB = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       aluop,
   input  logic [WIDTH-1:0] exe_a,
   input  logic [WIDTH-1:0] exe_b,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] exe_data_forward,
   input  logic [WIDTH-1:0] mem_data_forward,
   input  logic [1:0]       a_ctrl,
   input  logic [1:0]       b_ctrl,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] exe_output,
   output logic             zero_flag,
   output logic             busy
);
   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;
   localparam logic [3:0] OP_DIVU = 4'd11;
   localparam logic [3:0] OP_REMU = 4'd12;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] x_q, x_d;      // multiplicand (MUL) or divisor (DIVU/REMU)
   logic [WIDTH-1:0] y_q, y_d;      // multiplier (MUL) or dividend shifting into quotient
   logic [WIDTH-1:0] acc_q, acc_d;  // partial product or partial remainder
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d;

   logic [WIDTH-1:0] op_a, op_b, shamt_ext, alu_res;
   logic [SHW-1:0]   sh;
   logic [WIDTH:0]   rem_sh, rem_try;
   logic             accept, is_iter;

   always_comb begin
      shamt_ext = '0;
      shamt_ext[SHW-1:0] = imm[SH_LSB+SHW-1:SH_LSB];
      case (a_ctrl)
         2'd0:    op_a = exe_a;
         2'd1:    op_a = shamt_ext;
         2'd2:    op_a = exe_data_forward;
         default: op_a = mem_data_forward;
      endcase
      case (b_ctrl)
         2'd0:    op_b = exe_b;
         2'd1:    op_b = imm;
         2'd2:    op_b = exe_data_forward;
         default: op_b = mem_data_forward;
      endcase
   end

   // DIVU/REMU only reach this path with a zero divisor; nonzero divisors iterate.
   always_comb begin
      sh = op_a[SHW-1:0];
      case (aluop)
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SLL:  alu_res = op_b << sh;
         OP_SRL:  alu_res = op_b >> sh;
         OP_SRA:  alu_res = $signed(op_b) >>> sh;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
         OP_DIVU: alu_res = '1;
         OP_REMU: alu_res = op_a;
         default: alu_res = '0;
      endcase
   end

   // Restoring division: the top bit of rem_try is the borrow of the trial subtract.
   always_comb begin
      rem_sh  = {acc_q, y_q[WIDTH-1]};
      rem_try = rem_sh - {1'b0, x_q};
   end

   assign in_ready = (state_q == IDLE) || (state_q == HOLD && out_ready);
   assign accept   = in_valid && in_ready;
   assign is_iter  = (aluop == OP_MUL) ||
                     ((aluop == OP_DIVU || aluop == OP_REMU) && op_b != '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      x_d     = x_q;
      y_d     = y_q;
      acc_d   = acc_q;
      res_d   = res_q;
      zero_d  = zero_q;

      case (state_q)
         BUSY: begin
            if (op_q == OP_MUL) begin
               acc_d = acc_q + (y_q[0] ? x_q : '0);
               x_d   = x_q << 1;
               y_d   = y_q >> 1;
            end else if (!rem_try[WIDTH]) begin
               acc_d = rem_try[WIDTH-1:0];
               y_d   = {y_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = rem_sh[WIDTH-1:0];
               y_d   = {y_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               res_d   = (op_q == OP_DIVU) ? y_d : acc_d;
               zero_d  = (res_d == '0);
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: ;
      endcase

      if (accept) begin
         op_d = aluop;
         if (is_iter) begin
            state_d = BUSY;
            cnt_d   = CW'(WIDTH);
            acc_d   = '0;
            if (aluop == OP_MUL) begin
               x_d = op_a;
               y_d = op_b;
            end else begin
               x_d = op_b;
               y_d = op_a;
            end
         end else begin
            state_d = HOLD;
            res_d   = alu_res;
            zero_d  = (alu_res == '0);
         end
      end

      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
         res_d   = res_q;
         zero_d  = zero_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         x_q     <= x_d;
         y_q     <= y_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
      end
   end

   assign out_valid  = (state_q == HOLD);
   assign busy       = (state_q == BUSY);
   assign exe_output = res_q;
   assign zero_flag  = zero_q;
endmodule

// File: tb/tb_exe_unit_mc.sv
// Directed bench for exe_unit_mc: handshakes, ALU ops, iterative mul/div, backpressure,
// flush and reset, with hand-computed expected values.
module tb_exe_unit_mc;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  aluop;
   logic [31:0] exe_a, exe_b, imm, exe_data_forward, mem_data_forward;
   logic [1:0]  a_ctrl, b_ctrl;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] exe_output;
   logic        zero_flag;
   logic        busy;

   int tests_run    = 0;
   int tests_failed = 0;

   exe_unit_mc #(.WIDTH(32), .SH_LSB(5)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .aluop            (aluop),
      .exe_a            (exe_a),
      .exe_b            (exe_b),
      .imm              (imm),
      .exe_data_forward (exe_data_forward),
      .mem_data_forward (mem_data_forward),
      .a_ctrl           (a_ctrl),
      .b_ctrl           (b_ctrl),
      .flush            (flush),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .exe_output       (exe_output),
      .zero_flag        (zero_flag),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [1:0] ac, input logic [1:0] bc,
                        input logic [31:0] fe, input logic [31:0] fm);
      aluop            = op;
      exe_a            = a;
      exe_b            = b;
      imm              = im;
      a_ctrl           = ac;
      b_ctrl           = bc;
      exe_data_forward = fe;
      mem_data_forward = fm;
      in_valid         = 1'b1;
   endtask

   // Called just after a rising edge; returns just after the accept edge.
   task automatic single_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] im, input logic [1:0] ac,
                            input logic [1:0] bc, input logic [31:0] fe, input logic [31:0] fm,
                            input logic [31:0] exp);
      drive(op, a, b, im, ac, bc, fe, fm);
      #1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Scramble forward sources after accept; the held result must not follow them.
      exe_data_forward = 32'hDEAD_BEEF;
      mem_data_forward = 32'h1234_5678;
      $display("[TB] %s -> %08h zero=%0d", tag, exe_output, zero_flag);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check(tag, exe_output, exp);
      check({tag, "_zero"}, 32'(zero_flag), 32'(exp == 32'd0));
   endtask

   task automatic multi_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      int busy_n;
      drive(op, a, b, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 1;
      busy_n   = 0;
      while (!out_valid && lat < 100) begin
         if (busy) busy_n++;
         @(posedge clk);
         #1;
         lat++;
      end
      $display("[TB] %s -> %08h latency=%0d busy=%0d", tag, exe_output, lat, busy_n);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
      check(tag, exe_output, exp);
      check({tag, "_zero"}, 32'(zero_flag), 32'(exp == 32'd0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen_valid;
      rst       = 1'b1;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      drive(4'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_exe_output", exe_output, 32'd0);
      check("rst_zero", 32'(zero_flag), 32'd1);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);

      // Back-to-back single-cycle ops, including forwarded and shamt operands.
      single_op("add", 4'd0, 32'd5, 32'd7, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'h0000_000C);
      single_op("sub_fwd", 4'd1, 32'd7, 32'd3, 32'd0, 2'd0, 2'd2, 32'd7, 32'd0, 32'd0);
      single_op("sra", 4'd7, 32'd0, 32'h8000_0000, 32'h0000_0080, 2'd1, 2'd0, 32'd0, 32'd0,
                32'hF800_0000);
      single_op("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd1);
      single_op("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0);
      single_op("sll_memfwd", 4'd5, 32'd0, 32'd0, 32'd1, 2'd3, 2'd1, 32'd0, 32'd8, 32'h0000_0100);
      single_op("srl", 4'd6, 32'd4, 32'h8000_0000, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'h0800_0000);
      single_op("xor", 4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0,
                32'h0FF0_0FF0);
      single_op("and", 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0,
                32'hF000_F000);
      single_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd1);
      single_op("op13", 4'd13, 32'd9, 32'd9, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      check("idle_after_hold", 32'(out_valid), 32'd0);

      // Iterative ops and divide-by-zero shortcut.
      multi_op("mul", 4'd10, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 33);
      multi_op("mul_allones", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33);
      multi_op("divu", 4'd11, 32'd100, 32'd7, 32'd14, 33);
      multi_op("remu", 4'd12, 32'd100, 32'd7, 32'd2, 33);
      multi_op("divu_by1", 4'd11, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
      multi_op("remu_exact", 4'd12, 32'd49, 32'd7, 32'd0, 33);
      multi_op("divu_zero", 4'd11, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
      multi_op("remu_zero", 4'd12, 32'd9, 32'd0, 32'd9, 1);
      @(posedge clk);
      #1;

      // Backpressure: result held while out_ready is low, next op taken on release.
      out_ready = 1'b0;
      single_op("bp_add", 4'd0, 32'd3, 32'd4, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd7);
      drive(4'd3, 32'h0000_000F, 32'h0000_00F0, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold_data", exe_output, 32'd7);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      $display("[TB] bp_or -> %08h", exe_output);
      check("bp_or", exe_output, 32'h0000_00FF);
      check("bp_or_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;

      // Flush during the 10th busy cycle of a MUL.
      drive(4'd10, 32'd3, 32'd5, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk);
         #1;
      end
      check("flush_busy_before", 32'(busy), 32'd1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_busy_after", 32'(busy), 32'd0);
      seen_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      $display("[TB] flush_mul -> out_valid_seen=%0d exe_output=%08h", seen_valid, exe_output);
      check("flush_no_valid", 32'(seen_valid), 32'd0);
      check("flush_keeps_output", exe_output, 32'h0000_00FF);
      single_op("post_flush_add", 4'd0, 32'd1, 32'd2, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd3);
      @(posedge clk);
      #1;

      // Reset in the middle of a DIVU.
      drive(4'd11, 32'd100, 32'd7, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      $display("[TB] reset_mid_divu -> out_valid=%0d exe_output=%08h", out_valid, exe_output);
      check("rst2_out_valid", 32'(out_valid), 32'd0);
      check("rst2_exe_output", exe_output, 32'd0);
      check("rst2_zero", 32'(zero_flag), 32'd1);
      check("rst2_busy", 32'(busy), 32'd0);
      check("rst2_in_ready", 32'(in_ready), 32'd1);
      seen_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      check("rst2_no_valid", 32'(seen_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
